mux_arb_n: RTL

- Parametrised N-to-1 datapath selector with a registered output and per-channel valid/ready handshakes.
- Generalises the fixed 8:1 32-bit mux tree with:
  - arbitrary width and channel count
  - a fixed-select mode and a round-robin arbitration mode
  - one output register stage with backpressure
- Sits between multiple result/operand producers (ALU, memory read, immediate, forwarding paths) and a single downstream consumer.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 38 +++
 rtl/mux_arb_n.sv | 102 ++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the N-to-1 registered arbiter/selector.
// Holds the mode encoding and the channel-index width helper.
package mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: grants the first requester
// after `last`, wrapping modulo N. Ports: req, last -> gnt, gnt_idx.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int SELW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic            found;
  logic [SELW-1:0] cand;
  int              pos;

  // last is always a legal index (< N), so one subtraction wraps.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    pos     = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      cand = SELW'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-to-1 selector with fixed/round-robin grant and one output register.
// Ports: in_valid/in_data/in_ready per channel, out_* registered side.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SELW  = idx_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic [WIDTH-1:0] ch [N];

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign ch[g] = in_data[g*WIDTH +: WIDTH];
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load_en;
  logic             xfer;
  logic [N-1:0]     rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  mux_mode_t        mode_e;

  assign mode_e  = mux_mode_t'(mode);
  assign load_en = !out_valid_q || out_ready;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req     (in_valid),
    .last    (last_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel (possible when N is not a power of 2) grants nothing.
  always_comb begin
    fix_gnt = '0;
    if (int'(sel) < N) fix_gnt[sel] = in_valid[sel];
  end

  assign grant = (mode_e == MODE_RR) ? rr_gnt : fix_gnt;
  assign gidx  = (mode_e == MODE_RR) ? rr_idx : sel;

  assign in_ready = (reset || !load_en) ? '0 : grant;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch[gidx];
      out_chan_d  = gidx;
      last_d      = gidx;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to N-1 so the first search starts at channel 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SELW'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
